band_tone_generator: RTL and testbench

BAND_TONE_GENERATOR -- requirements
Module: band_tone_generator

---
 rtl/band_tone_generator.sv | 126 ++++++++++++
 tb/tb_band_tone_generator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/band_tone_generator.sv
// Band tone generator: mixes up to n_bands triangle tones into one saturated
// signed sample per sample period, processing one band per clock.
module band_tone_generator #(
   parameter int clk_mhz        = 50,
   parameter int sample_rate_hz = 48000,
   parameter int n_bands        = 12,
   parameter int freq [n_bands] = '{132, 152, 174, 200, 230, 264, 303, 348, 400, 458, 525, 600},
   parameter int w_sound        = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [n_bands-1:0]        band_en,
   input  logic [3:0]                amplitude,
   output logic signed [w_sound-1:0] sound,
   output logic                      sample_valid,
   output logic                      clip
);

   localparam longint P        = (longint'(clk_mhz) * 1000000) / sample_rate_hz;
   localparam int     CNT_W    = $clog2(P);
   localparam int     KW       = (n_bands > 1) ? $clog2(n_bands) : 1;
   localparam longint TERM_MAX = longint'(1024) * 15 * n_bands;
   localparam int     ACC_NEED = $clog2(TERM_MAX + 1) + 1;
   localparam int     ACC_A    = (ACC_NEED > 20) ? ACC_NEED : 20;
   localparam int     ACC_W    = (ACC_A > w_sound + 1) ? ACC_A : w_sound + 1;

   localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((longint'(1) << (w_sound - 1)) - 1);
   localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

   // The whole band sweep plus saturation must fit between two ticks.
   if (P < n_bands + 3) begin : g_period_check
      $error("band_tone_generator: sample period too short for n_bands");
   end

   logic [23:0] inc_tbl [n_bands];
   for (genvar g = 0; g < n_bands; g++) begin : g_inc
      localparam longint INC = ((longint'(freq[g]) << 25) + sample_rate_hz) /
                               (2 * longint'(sample_rate_hz));
      assign inc_tbl[g] = INC[23:0];
   end

   function automatic logic signed [w_sound-1:0] saturate(input logic signed [ACC_W-1:0] a);
      if (a > S_MAX)      saturate = {1'b0, {(w_sound-1){1'b1}}};
      else if (a < S_MIN) saturate = {1'b1, {(w_sound-1){1'b0}}};
      else                saturate = a[w_sound-1:0];
   endfunction

   function automatic logic is_clipped(input logic signed [ACC_W-1:0] a);
      return (a > S_MAX) || (a < S_MIN);
   endfunction

   logic [CNT_W-1:0] tick_cnt;
   logic             tick;

   assign tick = (tick_cnt == CNT_W'(P - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

   state_t                   state;
   logic [KW-1:0]            k;
   logic [n_bands-1:0]       en_lat;
   logic [3:0]               amp_lat;
   logic signed [ACC_W-1:0]  acc;
   logic [23:0]              phase [n_bands];

   logic [23:0]              cur_phase;
   logic [10:0]              u;
   logic signed [11:0]       tri_v;
   logic signed [16:0]       term;

   // Triangle from the pre-update phase: fold the top half back down.
   always_comb begin
      cur_phase = phase[k];
      u         = cur_phase[23] ? ~cur_phase[22:12] : cur_phase[22:12];
      tri_v     = $signed({1'b0, u}) - 12'sd1024;
      if (en_lat[k]) term = tri_v * $signed({1'b0, amp_lat});
      else           term = 17'sd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         k            <= '0;
         en_lat       <= '0;
         amp_lat      <= '0;
         acc          <= '0;
         sound        <= '0;
         clip         <= 1'b0;
         sample_valid <= 1'b0;
         for (int i = 0; i < n_bands; i++) phase[i] <= '0;
      end else begin
         sample_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (tick) begin
                  en_lat  <= band_en;
                  amp_lat <= amplitude;
                  acc     <= '0;
                  k       <= '0;
                  state   <= ACCUM;
               end
            end
            ACCUM: begin
               acc      <= acc + ACC_W'(term);
               phase[k] <= phase[k] + inc_tbl[k];
               if (k == KW'(n_bands - 1)) state <= SAT;
               else                       k     <= k + 1'b1;
            end
            SAT: begin
               sound        <= saturate(acc);
               clip         <= is_clipped(acc);
               sample_valid <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_band_tone_generator.sv
// Self-checking bench for band_tone_generator: per-cycle comparison against a
// sample-level behavioural model, plus directed scenarios with known values.
module tb_band_tone_generator;

   localparam int P   = 1041;
   localparam int NB  = 12;
   localparam int LAT = NB + 1;
   localparam int FREQ [NB] = '{132, 152, 174, 200, 230, 264, 303, 348, 400, 458, 525, 600};

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NB-1:0]         band_en = '0;
   logic [3:0]            amplitude = '0;
   logic signed [15:0]    sound;
   logic                  sample_valid;
   logic                  clip;

   band_tone_generator dut (
      .clk          (clk),
      .rst          (rst),
      .band_en      (band_en),
      .amplitude    (amplitude),
      .sound        (sound),
      .sample_valid (sample_valid),
      .clip         (clip)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Sample-level model: phases per band, one pending sample in flight.
   longint m_phase [NB];
   longint m_inc   [NB];
   int     cyc;
   bit     pend;
   int     pend_due;
   longint pend_sound;
   bit     pend_clip;
   longint exp_sound;
   bit     exp_clip;
   bit     exp_valid;

   task automatic model_reset();
      for (int b = 0; b < NB; b++) m_phase[b] = 0;
      cyc       = 0;
      pend      = 0;
      exp_sound = 0;
      exp_clip  = 0;
      exp_valid = 0;
   endtask

   task automatic model_edge();
      longint sum;
      cyc++;
      if (pend && cyc == pend_due) begin
         exp_valid = 1;
         exp_sound = pend_sound;
         exp_clip  = pend_clip;
         pend      = 0;
      end
      if (cyc % P == 0) begin
         sum = 0;
         for (int b = 0; b < NB; b++) begin
            longint v = (m_phase[b] >> 12) % 2048;
            longint uu = (m_phase[b] >= 64'd8388608) ? 2047 - v : v;
            if (band_en[b]) sum += (uu - 1024) * longint'(amplitude);
            m_phase[b] = (m_phase[b] + m_inc[b]) % 64'd16777216;
         end
         pend     = 1;
         pend_due = cyc + LAT;
         if (sum > 32767)       begin pend_sound = 32767;  pend_clip = 1; end
         else if (sum < -32768) begin pend_sound = -32768; pend_clip = 1; end
         else                   begin pend_sound = sum;    pend_clip = 0; end
      end
   endtask

   task automatic step();
      @(posedge clk);
      exp_valid = 0;
      if (!rst) model_edge();
      #1;
      check("sample_valid", sample_valid, exp_valid);
      check("sound", sound, exp_sound);
      check("clip", clip, exp_clip);
   endtask

   task automatic do_reset(input int hold);
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_sound", sound, 0);
      check("rst_clip", clip, 0);
      check("rst_valid", sample_valid, 0);
      repeat (hold) step();
      rst = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!sample_valid && n < 2 * P + LAT);
      check("pulse_seen", sample_valid, 1);
   endtask

   initial begin
      int n;
      int rst_at;
      for (int b = 0; b < NB; b++)
         m_inc[b] = ((longint'(FREQ[b]) << 25) + 48000) / 96000;

      #2;
      do_reset(3);

      // All bands off: silent samples at the sample rate.
      band_en = '0; amplitude = 4'd15;
      wait_valid(n); check("first_latency", n, P + LAT);
      check("silent_sound", sound, 0);
      wait_valid(n); check("period", n, P);
      check("silent_clip", clip, 0);

      // Band 0 only, full gain.
      do_reset(1); band_en = 12'h001; amplitude = 4'd15;
      wait_valid(n); check("b0_first", sound, -15360);
      wait_valid(n); check("b0_second", sound, -15195);
      check("b0_clip", clip, 0);

      // All bands at phase 0 saturate negative.
      do_reset(1); band_en = 12'hFFF; amplitude = 4'd15;
      wait_valid(n); check("all_sat", sound, -32768);
      check("all_clip", clip, 1);

      // Zero gain still advances the phase.
      do_reset(1); band_en = 12'h001; amplitude = 4'd0;
      wait_valid(n); check("amp0_s1", sound, 0);
      wait_valid(n); check("amp0_s2", sound, 0);
      amplitude = 4'd1;
      wait_valid(n); check("amp1_phase", sound, -1002);

      // Reset five cycles into the band sweep abandons the sample.
      do_reset(1); band_en = 12'hFFF; amplitude = 4'd15;
      repeat (P + 5) step();
      do_reset(1);
      wait_valid(n); check("rst_restart", n, P + LAT);

      // Gain change mid-sweep only affects the following sample.
      do_reset(1); band_en = 12'h001; amplitude = 4'd15;
      repeat (P + 3) step();
      amplitude = 4'd0;
      wait_valid(n); check("amp_hold", sound, -15360);
      wait_valid(n); check("amp_next", sound, 0);

      // Random enables/gains at random moments, occasional reset near a tick.
      band_en = NB'($urandom); amplitude = 4'($urandom);
      for (int s = 0; s < 40; s++) begin
         rst_at = (s % 13 == 7) ? int'($urandom_range(P - 2, P + LAT + 2)) : -1;
         n = 0;
         do begin
            if ($urandom_range(0, 99) == 0) band_en   = NB'($urandom);
            if ($urandom_range(0, 99) == 0) amplitude = 4'($urandom);
            step();
            n++;
            if (n == rst_at) begin
               do_reset(1);
               n = 0;
               rst_at = -1;
            end
         end while (!sample_valid && n < 2 * P + LAT);
         check("rnd_pulse", sample_valid, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
